// File: rtl/div_exp_pkg.sv
// Shared constants for the exponent add/subtract datapath.
package div_exp_pkg;

    localparam int unsigned EXP_W_DEF = 8;
    localparam int unsigned BIAS_DEF  = 127;

    localparam logic OP_DIV = 1'b0;
    localparam logic OP_MUL = 1'b1;

    // Internal signed width: two guard bits above the exponent field hold
    // the full range of x +/- y +/- BIAS without wrapping.
    function automatic int unsigned int_width(input int unsigned exp_w);
        return exp_w + 2;
    endfunction

endpackage

// File: rtl/exp_addsub.sv
// Parametrised add/subtract: sum = a + b or a - b, cout = carry out (no-borrow when subtracting).
module exp_addsub #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] bb;

    // Two's-complement subtract by inverting b and injecting sub as carry-in.
    always_comb begin
        bb          = sub ? ~b : b;
        {cout, sum} = (W+1)'(a) + (W+1)'(bb) + (W+1)'(sub);
    end

endmodule

// File: rtl/div_exp_unit.sv
// Two-stage exponent unit for FP divide/multiply with saturation and valid/ready flow control.
module div_exp_unit
    import div_exp_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned BIAS  = BIAS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [EXP_W-1:0] x,
    input  logic [EXP_W-1:0] y,
    input  logic             norm_adj,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp_out,
    output logic [EXP_W-1:0] abs_diff,
    output logic             diff_neg,
    output logic             ovf,
    output logic             unf
);

    localparam int unsigned IW = int_width(EXP_W);
    localparam logic signed [IW-1:0] EXP_MAX = IW'((1 << EXP_W) - 1);

    // Stage 1 combinational results
    logic [EXP_W-1:0] d_sum;
    logic             d_nob;
    logic [EXP_W-1:0] abs_c;
    logic [IW-1:0]    raw_c;
    logic             unused_raw_cout;

    // Stage 1 registers
    logic             s1_full;
    logic [IW-1:0]    s1_raw;
    logic [EXP_W-1:0] s1_abs;
    logic             s1_neg;
    logic             s1_op;
    logic             s1_norm;

    // Stage 2 combinational results
    logic [IW-1:0]        biased;
    logic                 unused_bias_cout;
    logic signed [IW-1:0] r;
    logic [EXP_W-1:0]     exp_c;
    logic                 ovf_c;
    logic                 unf_c;

    logic s2_full;
    logic s2_adv;

    exp_addsub #(.W(EXP_W)) u_diff (
        .a    (x),
        .b    (y),
        .sub  (1'b1),
        .sum  (d_sum),
        .cout (d_nob)
    );

    exp_addsub #(.W(IW)) u_raw (
        .a    (IW'(x)),
        .b    (IW'(y)),
        .sub  (op == OP_DIV),
        .sum  (raw_c),
        .cout (unused_raw_cout)
    );

    exp_addsub #(.W(IW)) u_bias (
        .a    (s1_raw),
        .b    (IW'(BIAS)),
        .sub  (s1_op == OP_MUL),
        .sum  (biased),
        .cout (unused_bias_cout)
    );

    // Magnitude of x - y; a missing carry out means x < y.
    always_comb begin
        abs_c = d_nob ? d_sum : (~d_sum + EXP_W'(1'b1));
    end

    // Normalisation adjust and saturation of the biased result.
    always_comb begin
        r     = $signed(biased - IW'(s1_norm));
        exp_c = r[EXP_W-1:0];
        ovf_c = 1'b0;
        unf_c = 1'b0;
        if (r >= EXP_MAX) begin
            exp_c = '1;
            ovf_c = 1'b1;
        end else if (r[IW-1] || (r == '0)) begin
            exp_c = '0;
            unf_c = 1'b1;
        end
    end

    // Handshake: a stage advances when the stage after it is empty or draining.
    always_comb begin
        s2_adv    = !s2_full || out_ready;
        in_ready  = !s1_full || s2_adv;
        out_valid = s2_full;
    end

    // Stage 1 register: capture operands on an input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_full <= 1'b0;
            s1_raw  <= '0;
            s1_abs  <= '0;
            s1_neg  <= 1'b0;
            s1_op   <= 1'b0;
            s1_norm <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_full <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_raw  <= raw_c;
                s1_abs  <= abs_c;
                s1_neg  <= !d_nob;
                s1_op   <= op;
                s1_norm <= norm_adj;
            end
        end
    end

    // Stage 2 register: result payload, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_full  <= 1'b0;
            exp_out  <= '0;
            abs_diff <= '0;
            diff_neg <= 1'b0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_full <= s1_full;
            end
            if (s1_full && s2_adv) begin
                exp_out  <= exp_c;
                abs_diff <= s1_abs;
                diff_neg <= s1_neg;
                ovf      <= ovf_c;
                unf      <= unf_c;
            end
        end
    end

endmodule

// File: tb/tb_div_exp_unit.sv
// Directed and streaming checks for div_exp_unit with EXP_W=8, BIAS=127.
module tb_div_exp_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       op;
    logic [7:0] x;
    logic [7:0] y;
    logic       norm_adj;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] exp_out;
    logic [7:0] abs_diff;
    logic       diff_neg;
    logic       ovf;
    logic       unf;

    int checks = 0;
    int errors = 0;

    logic       s_op[256];
    logic [7:0] s_x[256];
    logic [7:0] s_y[256];
    logic       s_na[256];

    div_exp_unit #(.EXP_W(8), .BIAS(127)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .x         (x),
        .y         (y),
        .norm_adj  (norm_adj),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exp_out   (exp_out),
        .abs_diff  (abs_diff),
        .diff_neg  (diff_neg),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Reference: saturated biased exponent computed in plain integers.
    task automatic model(input logic o, input logic [7:0] a, input logic [7:0] b, input logic na,
                         output int e, output int ov, output int un, output int ad, output int ng);
        int r;
        r  = (o == 1'b1) ? (int'(a) + int'(b) - 127) : (int'(a) - int'(b) + 127);
        r  = r - int'(na);
        ov = 0;
        un = 0;
        if (r >= 255) begin
            e  = 255;
            ov = 1;
        end else if (r <= 0) begin
            e  = 0;
            un = 1;
        end else begin
            e = r;
        end
        ad = (a >= b) ? int'(a) - int'(b) : int'(b) - int'(a);
        ng = (a < b) ? 1 : 0;
    endtask

    // Single beat into an empty pipe with out_ready high; result expected two cycles later.
    task automatic send_one(input logic o, input int xi, input int yi, input logic na,
                            input int e, input int ev, input int eu, input int ead, input int en);
        logic [7:0] xv;
        logic [7:0] yv;
        xv = xi[7:0];
        yv = yi[7:0];
        @(negedge clk);
        op = o; x = xv; y = yv; norm_adj = na; in_valid = 1'b1;
        #1 check("in_ready", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("lat1_valid", int'(out_valid), 0);
        @(negedge clk);
        #1;
        check("out_valid", int'(out_valid), 1);
        check("exp_out", int'(exp_out), e);
        check("ovf", int'(ovf), ev);
        check("unf", int'(unf), eu);
        check("abs_diff", int'(abs_diff), ead);
        check("diff_neg", int'(diff_neg), en);
    endtask

    // Stream n beats from the s_* tables, holding out_ready low for the first stall cycles.
    task automatic run_stream(input int n, input int stall, output int cycles, output int blocked);
        int sent = 0;
        int got  = 0;
        int e, ov, un, ad, ng;
        cycles  = 0;
        blocked = 0;
        while (got < n && cycles < n + stall + 50) begin
            @(negedge clk);
            out_ready = (cycles >= stall);
            in_valid  = (sent < n);
            if (sent < n) begin
                op = s_op[sent]; x = s_x[sent]; y = s_y[sent]; norm_adj = s_na[sent];
            end
            #1;
            if (in_valid && !in_ready) blocked = 1;
            if (out_valid) begin
                model(s_op[got], s_x[got], s_y[got], s_na[got], e, ov, un, ad, ng);
                check("st_exp", int'(exp_out), e);
                check("st_ovf", int'(ovf), ov);
                check("st_unf", int'(unf), un);
                check("st_abs", int'(abs_diff), ad);
                check("st_neg", int'(diff_neg), ng);
                check("st_excl", int'(ovf && unf), 0);
                if (out_ready) got++;
            end
            if (in_valid && in_ready) sent++;
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("st_count", got, n);
    endtask

    initial begin
        int cyc;
        int blk;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 1'b0; x = '0; y = '0; norm_adj = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_exp", int'(exp_out), 0);
        check("rst_abs", int'(abs_diff), 0);
        check("rst_flags", int'({diff_neg, ovf, unf}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        //        op    x    y   na    exp ovf unf abs neg
        send_one(1'b0, 130, 127, 1'b0, 130, 0, 0,   3, 0);
        send_one(1'b0, 130, 127, 1'b1, 129, 0, 0,   3, 0);
        send_one(1'b0, 254,   1, 1'b0, 255, 1, 0, 253, 0);
        send_one(1'b0,   1, 254, 1'b0,   0, 0, 1, 253, 1);
        send_one(1'b1, 200, 200, 1'b0, 255, 1, 0,   0, 0);
        send_one(1'b1,  64,  63, 1'b0,   0, 0, 1,   1, 0);
        send_one(1'b1, 127, 127, 1'b0, 127, 0, 0,   0, 0);
        send_one(1'b0, 128,   0, 1'b0, 255, 1, 0, 128, 0);
        send_one(1'b0, 127,   0, 1'b0, 254, 0, 0, 127, 0);
        send_one(1'b1, 128,   0, 1'b0,   1, 0, 0, 128, 0);
        send_one(1'b1, 128,   0, 1'b1,   0, 0, 1, 128, 0);
        send_one(1'b0,   0, 127, 1'b1,   0, 0, 1, 127, 1);

        // Backpressure: four back-to-back beats, consumer stalled for three cycles.
        s_op[0] = 1'b0; s_x[0] = 8'd130; s_y[0] = 8'd127; s_na[0] = 1'b0;
        s_op[1] = 1'b1; s_x[1] = 8'd127; s_y[1] = 8'd127; s_na[1] = 1'b0;
        s_op[2] = 1'b0; s_x[2] = 8'd1;   s_y[2] = 8'd254; s_na[2] = 1'b0;
        s_op[3] = 1'b1; s_x[3] = 8'd200; s_y[3] = 8'd200; s_na[3] = 1'b1;
        run_stream(4, 3, cyc, blk);
        check("bp_blocked", blk, 1);
        check("bp_cycles", cyc, 7);

        // Reset with two beats in flight.
        @(negedge clk);
        out_ready = 1'b0;
        op = 1'b0; x = 8'd130; y = 8'd127; norm_adj = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        x = 8'd200; y = 8'd10;
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("pre_rst_valid", int'(out_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_ready", int'(in_ready), 1);
        check("mid_rst_exp", int'(exp_out), 0);
        check("mid_rst_abs", int'(abs_diff), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check("post_rst_idle", int'(out_valid), 0);
        end
        send_one(1'b1, 127, 127, 1'b0, 127, 0, 0, 0, 0);

        // Full-rate random stream.
        for (int i = 0; i < 256; i++) begin
            s_op[i] = 1'($urandom_range(0, 1));
            s_x[i]  = 8'($urandom_range(0, 255));
            s_y[i]  = 8'($urandom_range(0, 255));
            s_na[i] = 1'($urandom_range(0, 1));
        end
        run_stream(256, 0, cyc, blk);
        check("rand_throughput", cyc, 258);
        check("rand_no_block", blk, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
